// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central pipeline sequencer for the 5-stage core. Combines three hazard
// sources (load-use, taken branch/jump in ID, data-cache miss) into hold,
// flush, bubble and PC-write controls. It owns the cache-miss refill handshake
// FSM and keeps two saturating performance counters.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   id_rs_i, id_rt_i     source register indices of the instruction in ID
//   id_uses_rt_i         ID instruction reads rt as a source
//   ex_memread_i/ex_rt_i load in EX and its destination register
//   id_branch_taken_i    branch resolved taken in ID
//   id_jump_i            jump in ID
//   dcache_miss_i        MEM-stage data cache miss
//   dmem_ack_i           refill complete pulse
//   dmem_req_o           refill request (high while in MISS)
//   pipe_stall_o         freeze every pipeline register and the PC
//   pc_write_o           PC update enable
//   ifid_hd_o            hold IF/ID for a load-use hazard
//   ifid_flush_o         zero IF/ID after a taken branch/jump
//   idex_bubble_o        insert a NOP into ID/EX
//   stall_cnt_o          cycles spent stalled or holding for load-use
//   flush_cnt_o          cycles with an IF/ID flush
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_branch_taken_i,
  input  logic             id_jump_i,
  input  logic             dcache_miss_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             pipe_stall_o,
  output logic             pc_write_o,
  output logic             ifid_hd_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MISS   = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             load_use_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Refill FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Refill FSM next state; ack is only meaningful in MISS, and a miss seen in
  // RESUME is stale because the line was just filled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (dcache_miss_i) state_d = ST_MISS;
        else               state_d = ST_RUN;
      end
      ST_MISS: begin
        if (dmem_ack_i) state_d = ST_RESUME;
        else            state_d = ST_MISS;
      end
      ST_RESUME: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Load-use detection; r0 is hardwired zero so a load to it never hazards.
  always_comb begin
    load_use_s = ex_memread_i && (ex_rt_i != {REG_W{1'b0}}) &&
                 ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  end

  // Pipeline controls: stall beats load-use beats branch/jump flush. While
  // reset is asserted every control is forced low, including pc_write_o.
  always_comb begin
    dmem_req_o    = 1'b0;
    pipe_stall_o  = 1'b0;
    pc_write_o    = 1'b0;
    ifid_hd_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    if (rst_i) begin
      pc_write_o = 1'b0;
    end else begin
      dmem_req_o   = (state_q == ST_MISS);
      pipe_stall_o = ((state_q == ST_RUN) && dcache_miss_i) || (state_q == ST_MISS);
      if (pipe_stall_o) begin
        pc_write_o = 1'b0;
      end else if (load_use_s) begin
        // Branch in ID is re-resolved after the bubble, so no flush here.
        ifid_hd_o     = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (id_branch_taken_i || id_jump_i) begin
        ifid_flush_o = 1'b1;
        pc_write_o   = 1'b1;
      end else begin
        pc_write_o = 1'b1;
      end
    end
  end

  // Saturating counter next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((pipe_stall_o || ifid_hd_o) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (ifid_flush_o && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share all inputs: one with
// 32-bit counters, one with 4-bit counters to exercise saturation.
module tb_hazard_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic       id_uses_rt_i, ex_memread_i, id_branch_taken_i, id_jump_i;
  logic       dcache_miss_i, dmem_ack_i;

  logic        req_a, stall_a, pcw_a, hd_a, fl_a, bub_a;
  logic [31:0] scnt_a, fcnt_a;
  logic        req_b, stall_b, pcw_b, hd_b, fl_b, bub_b;
  logic [3:0]  scnt_b, fcnt_b;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .id_branch_taken_i(id_branch_taken_i), .id_jump_i(id_jump_i),
    .dcache_miss_i(dcache_miss_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(req_a), .pipe_stall_o(stall_a), .pc_write_o(pcw_a),
    .ifid_hd_o(hd_a), .ifid_flush_o(fl_a), .idex_bubble_o(bub_a),
    .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a));

  hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .id_branch_taken_i(id_branch_taken_i), .id_jump_i(id_jump_i),
    .dcache_miss_i(dcache_miss_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(req_b), .pipe_stall_o(stall_b), .pc_write_o(pcw_b),
    .ifid_hd_o(hd_b), .ifid_flush_o(fl_b), .idex_bubble_o(bub_b),
    .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check the six control outputs of instance A in one call.
  task automatic ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, req_a, stall_a, pcw_a, hd_a, fl_a, bub_a}, {26'd0, exp});
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Move to the middle of the cycle, away from the edge.
  task automatic settle;
    #4;
  endtask

  task automatic idle;
    id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rt_i = 5'd0;
    id_uses_rt_i = 1'b0; ex_memread_i = 1'b0;
    id_branch_taken_i = 1'b0; id_jump_i = 1'b0;
    dcache_miss_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  // Control vector order: {req, stall, pc_write, hd, flush, bubble}
  initial begin
    idle();
    rst_i = 1'b1;
    tick(); tick();
    settle();
    ctl("reset_ctl", 6'b000000);
    chk("reset_scnt", scnt_a, 32'd0);
    chk("reset_fcnt", fcnt_a, 32'd0);

    tick(); rst_i = 1'b0;
    settle();
    ctl("run_idle", 6'b001000);

    // Load-use on rs
    tick(); ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5;
    settle();
    ctl("lu_rs", 6'b000101);
    tick(); idle();
    settle();
    ctl("lu_rs_after", 6'b001000);
    chk("lu_scnt", scnt_a, 32'd1);

    // Load to r0 never hazards
    tick(); ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0;
    settle();
    ctl("lu_r0", 6'b001000);
    // Load-use on rt only when rt is used
    tick(); ex_rt_i = 5'd7; id_rs_i = 5'd3; id_rt_i = 5'd7; id_uses_rt_i = 1'b1;
    settle();
    ctl("lu_rt_used", 6'b000101);
    tick(); id_uses_rt_i = 1'b0;
    settle();
    ctl("lu_rt_unused", 6'b001000);
    tick(); idle();
    settle();
    chk("lu_scnt2", scnt_a, 32'd2);

    // Taken branch, then jump
    tick(); id_branch_taken_i = 1'b1;
    settle();
    ctl("branch", 6'b001010);
    tick(); id_branch_taken_i = 1'b0; id_jump_i = 1'b1;
    settle();
    ctl("jump", 6'b001010);
    tick(); idle();
    settle();
    chk("flush_cnt", fcnt_a, 32'd2);

    // Cache miss held, ack in the third MISS cycle
    tick(); dcache_miss_i = 1'b1;
    settle();
    ctl("miss_run", 6'b010000);
    tick(); settle();
    ctl("miss_1", 6'b110000);
    tick(); settle();
    ctl("miss_2", 6'b110000);
    tick(); dmem_ack_i = 1'b1;
    settle();
    ctl("miss_3", 6'b110000);
    tick(); dmem_ack_i = 1'b0;
    settle();
    ctl("resume", 6'b001000);
    chk("miss_scnt", scnt_a, 32'd6);
    tick(); dcache_miss_i = 1'b0;
    settle();
    ctl("miss_done", 6'b001000);
    chk("miss_scnt_hold", scnt_a, 32'd6);

    // Miss + load-use + branch in the same cycle
    tick(); dcache_miss_i = 1'b1; ex_memread_i = 1'b1; ex_rt_i = 5'd5;
    id_rs_i = 5'd5; id_branch_taken_i = 1'b1;
    settle();
    ctl("prio", 6'b010000);
    tick(); idle(); dmem_ack_i = 1'b1;
    settle();
    ctl("prio_miss", 6'b110000);
    tick(); idle();
    settle();
    ctl("prio_resume", 6'b001000);
    chk("prio_scnt", scnt_a, 32'd8);
    chk("prio_fcnt", fcnt_a, 32'd2);

    // Ack in RUN is ignored
    tick(); dmem_ack_i = 1'b1;
    settle();
    ctl("ack_run", 6'b001000);
    tick(); dmem_ack_i = 1'b0;
    settle();
    ctl("ack_run_after", 6'b001000);

    // Reset during MISS, then a late ack
    tick(); dcache_miss_i = 1'b1;
    tick(); dcache_miss_i = 1'b0;
    settle();
    ctl("pre_rst_miss", 6'b110000);
    tick(); rst_i = 1'b1;
    settle();
    ctl("rst_in_miss", 6'b000000);
    tick(); rst_i = 1'b0; dmem_ack_i = 1'b1;
    settle();
    ctl("late_ack", 6'b001000);
    chk("rst_scnt", scnt_a, 32'd0);
    chk("rst_fcnt", fcnt_a, 32'd0);
    tick(); dmem_ack_i = 1'b0;
    settle();
    ctl("late_ack_after", 6'b001000);

    // 20 stall cycles: 4-bit counter saturates
    tick(); dcache_miss_i = 1'b1;
    repeat (20) tick();
    settle();
    chk("sat_stall", {31'd0, stall_b}, 32'd1);
    chk("sat_scnt_b", {28'd0, scnt_b}, 32'd15);
    chk("sat_scnt_a", scnt_a, 32'd20);
    tick(); dcache_miss_i = 1'b0; dmem_ack_i = 1'b1;
    tick(); dmem_ack_i = 1'b0;
    settle();
    chk("sat_hold_b", {28'd0, scnt_b}, 32'd15);
    ctl("sat_resume", 6'b001000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
